mem_req_sched: RTL and testbench

//  Schedules line-sized memory transactions from NREQ cache-side requesters
//  (0 = dcache fill, 1 = dcache writeback, 2 = icache fill) onto the single

---
 rtl/mem_req_sched_pkg.sv | 26 ++
 rtl/mem_req_sched_if.sv | 28 ++
 rtl/mem_req_sched_picker.sv | 91 +++++++++
 rtl/mem_req_sched.sv | 135 +++++++++++++
 tb/tb_mem_req_sched.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_sched_pkg.sv
// Shared types and constants for the cache-side memory request scheduler.
package mem_req_sched_pkg;

  // Scheduler life cycle: launch, wait for the bus, hand the result back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int DEF_NREQ       = 3;
  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_LINE_W     = 512;
  localparam int DEF_STARVE_MAX = 8;

  // Requester slots as wired at the top level of the cache complex.
  localparam int REQ_DFILL = 0;
  localparam int REQ_DWB   = 1;
  localparam int REQ_IFILL = 2;

  // Width of a counter that must be able to hold the value smax.
  function automatic int cnt_width(input int smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/mem_req_sched_if.sv
// Master-side transaction port towards the Sysbus arbiter.
//
// Handshake: the master raises m_request together with stable m_addr,
// m_wdata and m_wrenable and keeps all of them unchanged until the slave
// returns a single-cycle m_done. For reads m_rdata is valid only in the
// m_done cycle. The master drops m_request combinationally in the m_done
// cycle, so a request is never seen high after its own completion.
interface mem_req_sched_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  logic              m_request;
  logic              m_wrenable;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic              m_done;
  logic [LINE_W-1:0] m_rdata;

  modport master (
    output m_request, m_wrenable, m_addr, m_wdata,
    input  m_done, m_rdata
  );

  modport slave (
    input  m_request, m_wrenable, m_addr, m_wdata,
    output m_done, m_rdata
  );
endinterface

// File: rtl/mem_req_sched_picker.sv
// Winner selection for the scheduler: fixed priority by index, overridden by
// any requester that has lost STARVE_MAX arbitrations in a row.
module mem_req_sched_picker
  import mem_req_sched_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  localparam int CNT_W     = cnt_width(STARVE_MAX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       valid_i,
  input  logic                  pick_i,
  output logic [NREQ-1:0]       grant_o,
  output logic                  any_o,
  output logic [NREQ*CNT_W-1:0] starve_o
);

  logic [CNT_W-1:0] starve_q [NREQ];
  logic [CNT_W-1:0] starve_d [NREQ];
  logic [NREQ-1:0]  forced;
  logic             found;

  assign any_o = |valid_i;

  // Starved requesters first (lowest index), otherwise lowest valid index.
  always_comb begin
    forced  = '0;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      forced[i] = valid_i[i] && (starve_q[i] == CNT_W'(STARVE_MAX));
    end
    if (|forced) begin
      for (int i = 0; i < NREQ; i++) begin
        if (forced[i] && !found) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (valid_i[i] && !found) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Counters move only on a pick: winner clears, waiting losers saturate up,
  // absent requesters clear.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      starve_d[i] = starve_q[i];
      if (pick_i) begin
        if (grant_o[i]) begin
          starve_d[i] = '0;
        end else if (valid_i[i]) begin
          if (starve_q[i] != CNT_W'(STARVE_MAX)) begin
            starve_d[i] = starve_q[i] + CNT_W'(1);
          end
        end else begin
          starve_d[i] = '0;
        end
      end
    end
  end

  // Starve counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        starve_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        starve_q[i] <= starve_d[i];
      end
    end
  end

  // Flattened copy of the counters for observation.
  always_comb begin
    starve_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      starve_o[i*CNT_W +: CNT_W] = starve_q[i];
    end
  end

endmodule

// File: rtl/mem_req_sched.sv
// Schedules line-sized transactions from the cache requesters onto the single
// arbiter master port, one outstanding at a time, and routes the completion
// (and read line) back to the requester that was granted.
module mem_req_sched
  import mem_req_sched_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_W     = DEF_LINE_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  localparam int CNT_W     = cnt_width(STARVE_MAX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LINE_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [LINE_W-1:0]      rdata,
  mem_req_sched_if.master        m_bus,
  output sched_state_e           dbg_state,
  output logic [NREQ*CNT_W-1:0]  dbg_starve,
  output logic                   dbg_spurious_done
);

  sched_state_e      state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              spurious_q, spurious_d;

  logic [NREQ-1:0]   grant;
  logic              any_req;
  logic              pick;

  assign pick = (state_q == IDLE) && any_req;

  mem_req_sched_picker #(
    .NREQ       (NREQ),
    .STARVE_MAX (STARVE_MAX)
  ) u_picker (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (req_valid),
    .pick_i   (pick),
    .grant_o  (grant),
    .any_o    (any_req),
    .starve_o (dbg_starve)
  );

  // Next state, latch capture, done routing and read-line capture.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    spurious_d = 1'b0;
    case (state_q)
      IDLE: begin
        spurious_d = m_bus.m_done;
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = grant;
          wr_d    = |(req_wr & grant);
          addr_d  = '0;
          wdata_d = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*LINE_W +: LINE_W];
            end
          end
        end
      end
      BUSY: begin
        if (m_bus.m_done) begin
          state_d = RESP;
          done_d  = gnt_q;
          if (!wr_q) begin
            rdata_d = m_bus.m_rdata;
          end
        end
      end
      RESP: begin
        spurious_d = m_bus.m_done;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      spurious_q <= spurious_d;
    end
  end

  // The request falls in the done cycle so the arbiter cannot relaunch it.
  assign m_bus.m_request  = (state_q == BUSY) && !m_bus.m_done;
  assign m_bus.m_wrenable = wr_q;
  assign m_bus.m_addr     = addr_q;
  assign m_bus.m_wdata    = wdata_q;

  assign req_done          = done_q;
  assign rdata             = rdata_q;
  assign dbg_state         = state_q;
  assign dbg_spurious_done = spurious_q;

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed plus randomized checks of the memory request scheduler against a
// transaction-level reference model (priority, starvation, latching, timing).
module tb_mem_req_sched;
  import mem_req_sched_pkg::*;

  localparam int NREQ  = 3;
  localparam int AW    = 64;
  localparam int LW    = 512;
  localparam int SMAX  = 8;
  localparam int CNT_W = $clog2(SMAX + 1);

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*LW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_done;
  logic [LW-1:0]        rdata;
  sched_state_e         dbg_state;
  logic [NREQ*CNT_W-1:0] dbg_starve;
  logic                 dbg_spurious_done;

  mem_req_sched_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_req_sched #(
    .NREQ(NREQ), .ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SMAX)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_wr            (req_wr),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_done          (req_done),
    .rdata             (rdata),
    .m_bus             (bus.master),
    .dbg_state         (dbg_state),
    .dbg_starve        (dbg_starve),
    .dbg_spurious_done (dbg_spurious_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model and scoreboard
  int              starve_m [NREQ];
  logic [LW-1:0]   rdata_m;
  logic [NREQ-1:0] exp_q [$];
  logic [NREQ-1:0] hold_mask;

  logic [AW-1:0]   addr_tab  [NREQ];
  logic [LW-1:0]   wdata_tab [NREQ];
  logic            wr_tab    [NREQ];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = addr_tab[i];
      req_wdata[i*LW +: LW] = wdata_tab[i];
      req_wr[i]             = wr_tab[i];
    end
  endtask

  // Winner from the arbitration rules; updates the model counters.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    int w = -1;
    for (int i = 0; i < NREQ; i++)
      if (w < 0 && v[i] && starve_m[i] == SMAX) w = i;
    for (int i = 0; i < NREQ; i++)
      if (w < 0 && v[i]) w = i;
    for (int i = 0; i < NREQ; i++) begin
      if (i == w) starve_m[i] = 0;
      else if (v[i]) starve_m[i] = (starve_m[i] < SMAX) ? starve_m[i] + 1 : SMAX;
      else starve_m[i] = 0;
    end
    return (w < 0) ? 0 : w;
  endfunction

  function automatic logic [LW-1:0] model_starve();
    logic [NREQ*CNT_W-1:0] p = '0;
    for (int i = 0; i < NREQ; i++) p[i*CNT_W +: CNT_W] = CNT_W'(starve_m[i]);
    return LW'(p);
  endfunction

  // One full transaction from an IDLE-bound DUT back to IDLE.
  task automatic serve(input int lat, input bit scramble, input bit drop_mid,
                       input bit x_wdata, output int g, output int got);
    logic [NREQ-1:0] v, exp_done;
    logic [AW-1:0]   ea;
    logic [LW-1:0]   ew, pat;
    logic            ewr;
    v   = req_valid;
    g   = model_pick(v);
    ea  = addr_tab[g];
    ew  = wdata_tab[g];
    ewr = wr_tab[g];
    exp_q.push_back(NREQ'(1) << g);
    cycle();
    req_valid = req_valid | hold_mask;
    chk("launch_req",  LW'(bus.m_request), LW'(1'b1));
    chk("launch_addr", LW'(bus.m_addr), LW'(ea));
    chk("launch_wren", LW'(bus.m_wrenable), LW'(ewr));
    chk("launch_wdata", bus.m_wdata, ew);
    for (int c = 0; c < lat; c++) begin
      if (scramble) begin
        addr_tab[g]  = {$urandom, $urandom};
        wdata_tab[g] = x_wdata ? 'x : rand_line();
        wr_tab[g]    = ~wr_tab[g];
        apply();
      end
      if (drop_mid) req_valid[g] = 1'b0;
      cycle();
      chk("busy_req",   LW'(bus.m_request), LW'(1'b1));
      chk("busy_addr",  LW'(bus.m_addr), LW'(ea));
      chk("busy_wren",  LW'(bus.m_wrenable), LW'(ewr));
      chk("busy_wdata", bus.m_wdata, ew);
      chk("busy_done",  LW'(req_done), LW'(0));
    end
    pat = rand_line();
    bus.m_rdata = pat;
    bus.m_done  = 1'b1;
    #1;
    chk("done_cycle_req", LW'(bus.m_request), LW'(1'b0));
    if (!ewr) rdata_m = pat;
    cycle();
    bus.m_done  = 1'b0;
    bus.m_rdata = rand_line();
    exp_done = exp_q.pop_front();
    got = -1;
    for (int i = 0; i < NREQ; i++) if (req_done[i]) got = i;
    chk("resp_done",  LW'(req_done), LW'(exp_done));
    chk("resp_rdata", rdata, rdata_m);
    chk("resp_req",   LW'(bus.m_request), LW'(1'b0));
    req_valid[g] = 1'b0;
    cycle();
    chk("idle_done",   LW'(req_done), LW'(0));
    chk("idle_req",    LW'(bus.m_request), LW'(1'b0));
    chk("idle_starve", LW'(dbg_starve), model_starve());
  endtask

  int g, got, waited, last_g;
  int exp_order [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 1, 0};
  logic [NREQ-1:0] add;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    bus.m_done = 1'b0; bus.m_rdata = '0;
    hold_mask = '0; rdata_m = '0;
    for (int i = 0; i < NREQ; i++) begin
      starve_m[i] = 0; addr_tab[i] = '0; wdata_tab[i] = '0; wr_tab[i] = 1'b0;
    end
    #12;
    chk("rst_req",    LW'(bus.m_request), LW'(1'b0));
    chk("rst_done",   LW'(req_done), LW'(0));
    chk("rst_rdata",  rdata, '0);
    chk("rst_state",  LW'(dbg_state), LW'(IDLE));
    chk("rst_starve", LW'(dbg_starve), LW'(0));
    reset = 1'b0;
    cycle();

    // T1 single read from icache fill
    addr_tab[REQ_IFILL] = 64'h1000; wr_tab[REQ_IFILL] = 1'b0;
    wdata_tab[REQ_IFILL] = rand_line(); apply();
    req_valid = 3'b100;
    serve(2, 0, 0, 0, g, got);
    chk("t1_grant", LW'(got), LW'(2));

    // T2 write from dcache writeback, wdata turns to X while in flight
    addr_tab[REQ_DWB] = 64'h2040; wr_tab[REQ_DWB] = 1'b1;
    wdata_tab[REQ_DWB] = rand_line(); apply();
    req_valid = 3'b010;
    serve(3, 1, 0, 1, g, got);
    chk("t2_grant", LW'(got), LW'(1));

    // T3 full contention: 0 and 1 alternate until 2 is forced in
    for (int i = 0; i < NREQ; i++) begin
      addr_tab[i] = 64'h4000 + AW'(i) * 64'h40; wr_tab[i] = 1'b0; wdata_tab[i] = rand_line();
    end
    apply();
    hold_mask = 3'b111; req_valid = 3'b111; waited = 0;
    for (int k = 0; k < 12; k++) begin
      serve($urandom_range(0, 2), 0, 0, 0, g, got);
      chk("t3_order", LW'(got), LW'(exp_order[k]));
      if (got == 2) begin
        chk("t3_starve_bound", LW'(waited <= SMAX), LW'(1'b1));
        waited = 0;
      end else begin
        waited++;
      end
    end
    hold_mask = '0;
    for (int k = 0; k < 4 && req_valid != 0; k++) serve(1, 0, 0, 0, g, got);
    chk("t3_drained", LW'(req_valid), LW'(0));

    // T6 requester withdraws mid-flight, then a stray done arrives in IDLE
    addr_tab[REQ_DFILL] = 64'h8000; wr_tab[REQ_DFILL] = 1'b0; apply();
    req_valid = 3'b001;
    serve(3, 0, 1, 0, g, got);
    chk("t6_grant", LW'(got), LW'(0));
    bus.m_done = 1'b1;
    cycle();
    bus.m_done = 1'b0;
    chk("t6_spurious_flag", LW'(dbg_spurious_done), LW'(1'b1));
    chk("t6_spurious_done", LW'(req_done), LW'(0));
    chk("t6_spurious_rdata", rdata, rdata_m);
    chk("t6_spurious_state", LW'(dbg_state), LW'(IDLE));
    cycle();
    chk("t6_flag_clear", LW'(dbg_spurious_done), LW'(1'b0));

    // Randomized traffic
    last_g = -1;
    for (int n = 0; n < 24; n++) begin
      add = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~req_valid;
      if (last_g >= 0) add[last_g] = 1'b0;
      if (req_valid == 0 && add == 0) add = (last_g == 0) ? 3'b010 : 3'b001;
      for (int i = 0; i < NREQ; i++) begin
        if (add[i]) begin
          addr_tab[i] = {$urandom, $urandom}; wdata_tab[i] = rand_line();
          wr_tab[i] = 1'($urandom_range(0, 1));
        end
      end
      apply();
      req_valid = req_valid | add;
      serve($urandom_range(0, 4), 1'($urandom_range(0, 1)), 0, 0, g, got);
      chk("rnd_grant", LW'(got), LW'(g));
      last_g = g;
    end
    for (int k = 0; k < NREQ && req_valid != 0; k++) serve(1, 0, 0, 0, g, got);

    // T5 async reset while a transaction is in flight
    addr_tab[0] = 64'hA000; addr_tab[1] = 64'hB000; wr_tab[0] = 1'b0; wr_tab[1] = 1'b0;
    apply();
    req_valid = 3'b011;
    g = model_pick(req_valid);
    cycle();
    chk("t5_busy_req", LW'(bus.m_request), LW'(1'b1));
    chk("t5_busy_starve", LW'(dbg_starve), model_starve());
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NREQ; i++) starve_m[i] = 0;
    rdata_m = '0;
    exp_q.delete();
    chk("t5_req_low",  LW'(bus.m_request), LW'(1'b0));
    chk("t5_state",    LW'(dbg_state), LW'(IDLE));
    chk("t5_starve",   LW'(dbg_starve), model_starve());
    chk("t5_rdata",    rdata, rdata_m);
    req_valid = '0;
    #3;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t5_post_done",  LW'(req_done), LW'(0));
      chk("t5_post_req",   LW'(bus.m_request), LW'(1'b0));
      chk("t5_post_state", LW'(dbg_state), LW'(IDLE));
    end

    chk("sb_empty", LW'(exp_q.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
